// File: rtl/sprite_blit.sv
// Sprite blitter: streams a SPR_W x SPR_H sprite from ROM into a framebuffer, skipping KEY pixels.
// Optional macro SPRITE_BLIT_CLIP_EN: accept any position and drop off-screen pixels instead of rejecting.
module sprite_blit #(
  parameter int          SPR_W = 22,
  parameter int          SPR_H = 22,
  parameter int          FB_W  = 640,
  parameter int          FB_H  = 480,
  parameter logic [11:0] KEY   = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_wdata
);

  localparam int NPIX = SPR_W * SPR_H;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        slot_q, slot_d;
  logic        on_q, on_d;
  logic [18:0] fbaddr_q, fbaddr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [10:0] xs, ys;
  logic        pix_ok;

  // 11-bit sums so a sprite hanging past the screen edge never wraps back on-screen
  assign xs     = {1'b0, px_q} + {1'b0, col_q};
  assign ys     = {1'b0, py_q} + {1'b0, row_q};
  assign pix_ok = (xs < 11'(FB_W)) && (ys < 11'(FB_H));

`ifndef SPRITE_BLIT_CLIP_EN
  logic fit;
  assign fit = ((12'(pos_x) + 12'(SPR_W)) <= 12'(FB_W)) &&
               ((12'(pos_y) + 12'(SPR_H)) <= 12'(FB_H));
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    col_d    = col_q;
    row_d    = row_q;
    px_d     = px_q;
    py_d     = py_q;
    slot_d   = 1'b0;
    on_d     = 1'b0;
    fbaddr_d = fbaddr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SPRITE_BLIT_CLIP_EN
          state_d = RUN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          px_d    = pos_x;
          py_d    = pos_y;
`else
          if (fit) begin
            state_d = RUN;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
            px_d    = pos_x;
            py_d    = pos_y;
          end else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        // Write-slot qualifiers are registered here so they line up with rom_data next cycle
        slot_d   = 1'b1;
        on_d     = pix_ok;
        fbaddr_d = 19'(22'(ys) * 22'(FB_W) + 22'(xs));
        if (addr_q == 16'(NPIX - 1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 16'd1;
          if (col_q == 10'(SPR_W - 1)) begin
            col_d = '0;
            row_d = row_q + 10'd1;
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      slot_q   <= 1'b0;
      on_q     <= 1'b0;
      fbaddr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      px_q     <= px_d;
      py_q     <= py_d;
      slot_q   <= slot_d;
      on_q     <= on_d;
      fbaddr_q <= fbaddr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign rom_addr = addr_q;
  assign fb_we    = slot_q && on_q && (rom_data != KEY);
  assign fb_addr  = fbaddr_q;
  assign fb_wdata = slot_q ? rom_data : 12'h000;

endmodule

// File: tb/tb_sprite_blit.sv
// Randomized and directed bench for sprite_blit against an event-list reference model.
module tb_sprite_blit;
  localparam int          SPR_W = 22;
  localparam int          SPR_H = 22;
  localparam int          FB_W  = 640;
  localparam int          FB_H  = 480;
  localparam int          N     = SPR_W * SPR_H;
  localparam logic [11:0] KEY   = 12'h000;
  localparam int          INF   = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        busy, done, err, fb_we;
  logic [15:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [18:0] fb_addr;
  logic [11:0] fb_wdata;

  sprite_blit #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FB_W(FB_W), .FB_H(FB_H), .KEY(KEY)) dut (
    .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .err(err), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
  );

  always #5 clk = ~clk;

  // cyc at a negedge names the current cycle; the next rising edge is edge cyc
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [11:0] rom [N];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct { int c; int a; int d; } wr_t;
  wr_t got_w[$], exp_w[$];
  int  got_done[$], exp_done[$], got_err[$], exp_err[$];
  int  blk_t[$], blk_cut[$];
  bit  busy_log[int];
  bit  mon_en = 1'b0;
  int  idle_from = 0;
  int  checks = 0, failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (fb_we) got_w.push_back('{cyc, int'(fb_addr), int'(fb_wdata)});
    if (done)  got_done.push_back(cyc);
    if (err)   got_err.push_back(cyc);
    busy_log[cyc] = busy;
  end

  // Reference: every observable event of a blit requested in cycle t, discarding events after cycle cut
  task automatic model_blit(int t, int px, int py, int cut);
    bit ok;
`ifdef SPRITE_BLIT_CLIP_EN
    ok = 1'b1;
`else
    ok = (px + SPR_W <= FB_W) && (py + SPR_H <= FB_H);
`endif
    if (t < idle_from) return;
    if (!ok) begin
      if (t + 1 <= cut) exp_err.push_back(t + 1);
      return;
    end
    for (int r = 0; r < SPR_H; r++)
      for (int c = 0; c < SPR_W; c++) begin
        int k = r * SPR_W + c;
        if (t + 2 + k <= cut && rom[k] != KEY && px + c < FB_W && py + r < FB_H)
          exp_w.push_back('{t + 2 + k, (py + r) * FB_W + (px + c), int'(rom[k])});
      end
    if (t + 2 + N <= cut) exp_done.push_back(t + 2 + N);
    blk_t.push_back(t);
    blk_cut.push_back(cut);
    idle_from = t + 2 + N;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_at(int e, int px, int py, int cut);
    wait_to(e);
    chk("sched", cyc, e);
    start = 1'b1;
    pos_x = 10'(px);
    pos_y = 10'(py);
    model_blit(cyc, px, py, cut);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_test();
    got_w.delete(); exp_w.delete();
    got_done.delete(); exp_done.delete();
    got_err.delete(); exp_err.delete();
    blk_t.delete(); blk_cut.delete();
    busy_log.delete();
    mon_en = 1'b1;
  endtask

  task automatic end_test(string name);
    int bad, hi, ehi;
    wait_to((idle_from > cyc ? idle_from : cyc) + 3);
    mon_en = 1'b0;
    chk({name, "_nwr"}, got_w.size(), exp_w.size());
    bad = -1;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      if (got_w[i] != exp_w[i]) begin
        $display("%s write %0d: cyc/addr/data got %0d/%0d/%h exp %0d/%0d/%h", name, i,
                 got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
        bad = i;
        break;
      end
    chk({name, "_wr_first_bad"}, bad, -1);
    chk({name, "_ndone"}, got_done.size(), exp_done.size());
    for (int i = 0; i < got_done.size() && i < exp_done.size(); i++)
      chk({name, "_done_cyc"}, got_done[i], exp_done[i]);
    chk({name, "_nerr"}, got_err.size(), exp_err.size());
    for (int i = 0; i < got_err.size() && i < exp_err.size(); i++)
      chk({name, "_err_cyc"}, got_err[i], exp_err[i]);
    ehi = 0;
    foreach (blk_t[i]) begin
      int t = blk_t[i], cut = blk_cut[i];
      int last = (t + 1 + N < cut) ? t + 1 + N : cut;
      ehi += last - t;
      chk({name, "_busy_first"}, busy_log.exists(t + 1) ? busy_log[t + 1] : 1'bx, 1);
      if (t + 1 + N <= cut)
        chk({name, "_busy_last"}, busy_log.exists(t + 1 + N) ? busy_log[t + 1 + N] : 1'bx, 1);
      if (t + 2 + N <= cut)
        chk({name, "_busy_done"}, busy_log.exists(t + 2 + N) ? busy_log[t + 2 + N] : 1'bx, 0);
    end
    hi = 0;
    foreach (busy_log[c]) if (busy_log[c]) hi++;
    chk({name, "_busy_cycles"}, hi, ehi);
  endtask

  task automatic fill_rom(int mode);
    for (int k = 0; k < N; k++)
      case (mode)
        0: rom[k] = 12'hF00;
        1: rom[k] = (k == 5) ? 12'h000 : 12'h0F0;
        default: rom[k] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      endcase
  endtask

  initial begin
    int t, px, py;
    fill_rom(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_start_ignored", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    idle_from = cyc;

    // Full sprite at origin
    begin_test();
    start_at(cyc + 1, 0, 0, INF);
    end_test("origin");

    // Single keyed pixel skipped
    fill_rom(1);
    begin_test();
    start_at(cyc + 1, 100, 50, INF);
    end_test("keyed");

    // Start while busy ignored, back-to-back start on the done cycle accepted
    fill_rom(0);
    begin_test();
    t = cyc + 1;
    start_at(t, 10, 20, INF);
    start_at(t + 100, 300, 300, INF);
    start_at(t + 2 + N, 5, 5, INF);
    end_test("b2b");

    // Reset mid-blit aborts, then a clean blit
    begin_test();
    t = cyc + 1;
    start_at(t, 0, 0, t + 200);
    wait_to(t + 200);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_fb_we", fb_we, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_fb_wdata", fb_wdata, 0);
    rst = 1'b1;
    idle_from = cyc + 1;
    wait_to(t + N + 5);
    end_test("abort");
    begin_test();
    start_at(cyc + 1, 0, 0, INF);
    end_test("after_abort");

    // Bottom-right corner: clipped or rejected depending on build
    fill_rom(0);
    begin_test();
    start_at(cyc + 1, 630, 470, INF);
    end_test("corner");

    // Randomized placements and content, with a stray start thrown in
    for (int i = 0; i < 8; i++) begin
      fill_rom(2);
      begin_test();
      if ($urandom_range(0, 1) == 1) begin
        px = $urandom_range(0, FB_W - SPR_W);
        py = $urandom_range(0, FB_H - SPR_H);
      end else begin
        px = $urandom_range(FB_W - SPR_W - 4, 1023);
        py = $urandom_range(FB_H - SPR_H - 4, 1023);
      end
      t = cyc + $urandom_range(1, 3);
      start_at(t, px, py, INF);
      start_at(t + $urandom_range(3, 400), $urandom_range(0, 200), $urandom_range(0, 200), INF);
      end_test("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sprite_blit.md
SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 SHALL have parameter SPR_W, default 22, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 22, sprite height in pixels.
REQ-003 SHALL have parameter FB_W, default 640, framebuffer stride and screen width in pixels.
REQ-004 SHALL have parameter FB_H, default 480, screen height in pixels.
REQ-005 SHALL have parameter KEY, default 12'h000, transparent colour.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  blit request, level-sampled.
REQ-009 SHALL have port pos_x  input  10  sprite top-left x, sampled on accept.
REQ-010 SHALL have port pos_y  input  10  sprite top-left y, sampled on accept.
REQ-011 SHALL have port busy  output  1  blit in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  one-cycle rejection pulse.
REQ-014 SHALL have port rom_addr  output  16  sprite ROM address, row*SPR_W+col.
REQ-015 SHALL have port rom_data  input  12  ROM pixel, valid one cycle after rom_addr.
REQ-016 SHALL have port fb_we  output  1  framebuffer write strobe.
REQ-017 SHALL have port fb_addr  output  19  framebuffer address, y*FB_W+x.
REQ-018 SHALL have port fb_wdata  output  12  framebuffer pixel {r,g,b}.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on accepted start, RUN->DRAIN after last ROM address, DRAIN->IDLE after last write slot.
REQ-020 SHALL accept start only in IDLE; start while busy ignored, no effect on current blit.
REQ-021 SHALL, for start accepted at edge T, assert busy from cycle T+1 through the last write slot inclusive.
REQ-022 SHALL drive rom_addr=k in cycle T+1+k, k=0..SPR_W*SPR_H-1, row-major, col wrapping to 0 and row incrementing at col=SPR_W-1.
REQ-023 SHALL present pixel k's write slot in cycle T+2+k: fb_we=1 iff rom_data!=KEY and pixel on-screen; fb_addr=(pos_y+row)*FB_W+(pos_x+col); fb_wdata=rom_data.
REQ-024 SHALL compute x/y sums at 11 bits so no wrap; on-screen means x<FB_W and y<FB_H.
REQ-025 SHALL pulse done for one cycle at T+2+SPR_W*SPR_H (T+486 by default), busy low in that cycle; start may be accepted that same cycle.
REQ-026 SHALL hold fb_we=0, done=0, err=0 whenever not specified otherwise; rom_addr holds last value in IDLE.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, enter IDLE with busy=0, done=0, err=0, fb_we=0, rom_addr=0, fb_addr=0, fb_wdata=0.
REQ-028 SHALL, on reset mid-blit, abort immediately: no further fb_we, no done pulse.
REQ-029 SHALL ignore start in any cycle where rst=0.

Configuration
REQ-030 SHALL use macro SPRITE_BLIT_CLIP_EN.
REQ-031 SHALL, with SPRITE_BLIT_CLIP_EN defined, accept any position and suppress fb_we for off-screen pixels per REQ-023; err never asserted.
REQ-032 SHALL, without SPRITE_BLIT_CLIP_EN, reject start when pos_x+SPR_W>FB_W or pos_y+SPR_H>FB_H: err pulses at T+1, stays IDLE, busy=0, no done, no writes.

Verification
REQ-033 SHALL cover: start pos (0,0), ROM all 12'hF00 -> 484 writes, fb_addr 0..21, 640..661, ..., 13440..13461, done at T+486.
REQ-034 SHALL cover: ROM pixel 5 = 12'h000, others 12'h0F0, pos (100,50) -> 483 writes, fb_addr 32105 skipped.
REQ-035 SHALL cover: start pulsed again at T+100 -> ignored, single done at T+486, then start at T+486 accepted, busy at T+487.
REQ-036 SHALL cover: rst=0 at T+200 -> fb_we 0 from T+201, no done, busy 0; later start at (0,0) runs full 484 writes.
REQ-037 SHALL cover: pos (630,470) with clip -> 100 writes (cols 0..9, rows 0..9), done at T+486; without clip -> err pulse at T+1, no writes.
